// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the round sequencer
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SHOW = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int NUM_BUTTONS = 3;

  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [NUM_BUTTONS-1:0] onehot_target(input logic [7:0] r);
    logic [7:0] idx;
    idx = r % 8'd3;
    case (idx)
      8'd0:    return 3'b001;
      8'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

endpackage

// File: rtl/round_sequencer_if.sv
// rtl/round_sequencer_if.sv - game controller / button / LED signals of the round sequencer
interface round_sequencer_if;
  import game_pkg::*;

  logic                   startGame;
  logic [NUM_BUTTONS-1:0] btn;
  logic [NUM_BUTTONS-1:0] ledTarget;
  logic [7:0]             score;
  logic [7:0]             roundNum;
  logic                   hit;
  logic                   miss;
  logic                   stopOut;

  modport master (
    output startGame, btn,
    input  ledTarget, score, roundNum, hit, miss, stopOut
  );

  modport slave (
    input  startGame, btn,
    output ledTarget, score, roundNum, hit, miss, stopOut
  );

endinterface

// File: rtl/round_sequencer_lfsr8.sv
// rtl/round_sequencer_lfsr8.sv - free-running 8-bit Fibonacci LFSR for target selection
module lfsr8
  import game_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= SEED;
    end else begin
      q <= {q[6:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - timed round FSM: gap, lit target window, hit/miss scoring, stop
module round_sequencer
  import game_pkg::*;
#(
  parameter int         NUM_ROUNDS    = 10,
  parameter int         WINDOW_CYCLES = 25000000,
  parameter int         GAP_CYCLES    = 12500000,
  parameter int         TIMER_W       = 26,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  round_sequencer_if.slave  bus
);

  localparam logic [TIMER_W-1:0] GAP_LOAD    = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WINDOW_LOAD = TIMER_W'(WINDOW_CYCLES - 1);
  localparam logic [7:0]         LAST_ROUND  = 8'(NUM_ROUNDS - 1);

  state_t                 state_q, state_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic [NUM_BUTTONS-1:0] btn_prev_q;
  logic [NUM_BUTTONS-1:0] led_q, led_d;
  logic [7:0]             score_q, score_d;
  logic [7:0]             round_q, round_d;
  logic                   hit_q, hit_d;
  logic                   miss_q, miss_d;
  logic                   stop_q, stop_d;
  logic [7:0]             lfsr_q;
  logic [NUM_BUTTONS-1:0] rise;
  logic                   decided;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign rise = bus.btn & ~btn_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      btn_prev_q <= '0;
      led_q      <= '0;
      score_q    <= '0;
      round_q    <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      btn_prev_q <= bus.btn;
      led_q      <= led_d;
      score_q    <= score_d;
      round_q    <= round_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      stop_q     <= stop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    led_d   = led_q;
    score_d = score_q;
    round_d = round_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    stop_d  = 1'b0;
    decided = 1'b0;

    case (state_q)
      IDLE: begin
        led_d = '0;
        if (bus.startGame) begin
          score_d = '0;
          round_d = '0;
          timer_d = GAP_LOAD;
          state_d = GAP;
        end
      end

      GAP: begin
        led_d = '0;
        if (!bus.startGame) begin
          state_d = IDLE;
        end else if (timer_q == '0) begin
          led_d   = onehot_target(lfsr_q);
          timer_d = WINDOW_LOAD;
          state_d = SHOW;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      SHOW: begin
        if (!bus.startGame) begin
          led_d   = '0;
          state_d = IDLE;
        end else begin
          // a wrong button outranks the right one; any press outranks timeout
          if (|(rise & ~led_q)) begin
            miss_d  = 1'b1;
            decided = 1'b1;
          end else if (|(rise & led_q)) begin
            hit_d   = 1'b1;
            decided = 1'b1;
            if (score_q != 8'hFF) begin
              score_d = score_q + 1'b1;
            end
          end else if (timer_q == '0) begin
            miss_d  = 1'b1;
            decided = 1'b1;
          end else begin
            timer_d = timer_q - 1'b1;
          end

          if (decided) begin
            led_d   = '0;
            round_d = round_q + 1'b1;
            if (round_q == LAST_ROUND) begin
              stop_d  = 1'b1;
              state_d = DONE;
            end else begin
              timer_d = GAP_LOAD;
              state_d = GAP;
            end
          end
        end
      end

      DONE: begin
        led_d = '0;
        if (!bus.startGame) begin
          state_d = IDLE;
        end else begin
          stop_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
        led_d   = '0;
        score_d = '0;
        round_d = '0;
      end
    endcase
  end

  assign bus.ledTarget = led_q;
  assign bus.score     = score_q;
  assign bus.roundNum  = round_q;
  assign bus.hit       = hit_q;
  assign bus.miss      = miss_q;
  assign bus.stopOut   = stop_q;

endmodule

// File: tb/tb_round_sequencer.sv
// tb/tb_round_sequencer.sv - randomized scoreboard bench for round_sequencer
module tb_round_sequencer;

  localparam int NR  = 3;
  localparam int WIN = 8;
  localparam int GAP = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  round_sequencer_if bus ();

  round_sequencer #(
    .NUM_ROUNDS    (NR),
    .WINDOW_CYCLES (WIN),
    .GAP_CYCLES    (GAP),
    .TIMER_W       (8),
    .LFSR_SEED     (8'hA5)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  typedef struct {
    bit is_hit;
    int when;
    int score;
    int rnd;
    bit stop;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int m_score  = 0;
  int m_round  = 0;
  int exp_lit  = 0;

  logic [7:0] m_lfsr      = 8'hA5;
  logic [7:0] m_lfsr_prev = 8'hA5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // sequence of values the target generator holds, one per clock
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr      <= 8'hA5;
      m_lfsr_prev <= 8'hA5;
    end else begin
      m_lfsr_prev <= m_lfsr;
      m_lfsr      <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].when < cyc) begin
        checks++;
        failures++;
        $display("FAIL pulse_missing expected_at=%0d now=%0d", sb[0].when, cyc);
        void'(sb.pop_front());
      end
      if (bus.hit || bus.miss) begin
        check("hit_miss_exclusive", 32'(bus.hit & bus.miss), 0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse hit=%0d miss=%0d cycle=%0d", bus.hit, bus.miss, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("pulse_cycle", cyc, mon_e.when);
          check("pulse_is_hit", 32'(bus.hit), 32'(mon_e.is_hit));
          check("pulse_score", 32'(bus.score), mon_e.score);
          check("pulse_round", 32'(bus.roundNum), mon_e.rnd);
          check("pulse_stop", 32'(bus.stopOut), 32'(mon_e.stop));
        end
      end
    end
  end

  task automatic start_game();
    @(negedge clk);
    bus.startGame = 1'b1;
    m_score = 0;
    m_round = 0;
    exp_lit = cyc + GAP + 1;
  endtask

  task automatic wait_lit(output bit ok, output int lit, output logic [2:0] tgt);
    logic [2:0] one = 3'b001;
    ok  = 1'b0;
    lit = 0;
    tgt = '0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.ledTarget != 3'b000) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL led_timeout actual=0 required=lit");
    end else begin
      lit = cyc;
      tgt = one << (m_lfsr_prev % 3);
      check("gap_length", lit, exp_lit);
      check("target_led", 32'(bus.ledTarget), 32'(tgt));
    end
  endtask

  // act: 0 correct press, 1 wrong press, 2 no press, 3 held across gap then re-press
  task automatic play_round(input int act, input int d);
    exp_t       e;
    bit         ok;
    int         lit;
    logic [2:0] tgt;
    logic [2:0] other;
    if (act == 3) bus.btn = 3'b111;
    wait_lit(ok, lit, tgt);
    if (!ok) return;
    other = {tgt[1:0], tgt[2]};
    m_round++;
    e.rnd  = m_round;
    e.stop = (m_round == NR);
    case (act)
      0: begin
        repeat (d) @(negedge clk);
        bus.btn  = tgt;
        e.is_hit = 1'b1;
        e.when   = lit + d + 1;
      end
      1: begin
        repeat (d) @(negedge clk);
        bus.btn  = ($urandom_range(0, 1) == 0) ? other : (other | tgt);
        e.is_hit = 1'b0;
        e.when   = lit + d + 1;
      end
      2: begin
        e.is_hit = 1'b0;
        e.when   = lit + WIN;
      end
      default: begin
        repeat (d) @(negedge clk);
        bus.btn = 3'b000;
        @(negedge clk);
        bus.btn  = tgt;
        e.is_hit = 1'b1;
        e.when   = lit + d + 2;
      end
    endcase
    if (e.is_hit && m_score < 255) m_score++;
    e.score = m_score;
    sb.push_back(e);
    while (cyc < e.when) @(negedge clk);
    bus.btn = 3'b000;
    exp_lit = e.when + GAP;
  endtask

  task automatic end_game();
    repeat (3) @(negedge clk);
    check("done_stop", 32'(bus.stopOut), 1);
    check("done_led", 32'(bus.ledTarget), 0);
    check("done_score", 32'(bus.score), m_score);
    check("done_round", 32'(bus.roundNum), NR);
    bus.startGame = 1'b0;
    @(negedge clk);
    check("stop_release", 32'(bus.stopOut), 0);
    check("idle_score_held", 32'(bus.score), m_score);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_led"}, 32'(bus.ledTarget), 0);
    check({tag, "_score"}, 32'(bus.score), 0);
    check({tag, "_round"}, 32'(bus.roundNum), 0);
    check({tag, "_hit"}, 32'(bus.hit), 0);
    check({tag, "_miss"}, 32'(bus.miss), 0);
    check({tag, "_stop"}, 32'(bus.stopOut), 0);
  endtask

  initial begin
    bit         ok;
    int         lit;
    logic [2:0] tgt;
    int         act;

    bus.startGame = 1'b0;
    bus.btn       = 3'b000;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    start_game();
    for (int r = 0; r < NR; r++) play_round(0, 2);
    end_game();

    start_game();
    for (int r = 0; r < NR; r++) play_round(2, 0);
    end_game();

    start_game();
    play_round(1, 3);
    play_round(3, 2);
    play_round(0, 7);
    end_game();

    repeat (5) begin
      start_game();
      for (int r = 0; r < NR; r++) begin
        act = int'($urandom_range(0, 3));
        play_round(act, (act == 3) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 7)));
      end
      end_game();
    end

    // abort mid-window after one hit, then restart
    start_game();
    play_round(0, 2);
    wait_lit(ok, lit, tgt);
    bus.startGame = 1'b0;
    @(negedge clk);
    check("abort_led", 32'(bus.ledTarget), 0);
    check("abort_score", 32'(bus.score), 1);
    check("abort_round", 32'(bus.roundNum), 1);
    check("abort_stop", 32'(bus.stopOut), 0);
    repeat (WIN + 2) @(negedge clk);
    check("abort_idle_led", 32'(bus.ledTarget), 0);
    start_game();
    @(negedge clk);
    check("restart_score", 32'(bus.score), 0);
    check("restart_round", 32'(bus.roundNum), 0);
    for (int r = 0; r < NR; r++) play_round(1, int'($urandom_range(0, 7)));
    end_game();

    // asynchronous reset while a target is lit
    start_game();
    play_round(0, 1);
    wait_lit(ok, lit, tgt);
    @(negedge clk);
    #2;
    rst_n         = 1'b0;
    bus.startGame = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    repeat (3) @(negedge clk);
    check_all_zero("post_reset_idle");
    start_game();
    for (int r = 0; r < NR; r++) play_round(0, int'($urandom_range(0, 7)));
    end_game();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog time_limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
- Sequences the timed rounds of a game once the game controller raises startGame.
- Each round: picks a pseudo-random target button, lights its LED, and opens a response window.
- Scores the player's registered button outputs as hit or miss.
- After NUM_ROUNDS rounds, raises stopOut, which the game controller consumes as its stop input.

Parameters:
- NUM_ROUNDS, 10, rounds per game (1..255).
- WINDOW_CYCLES, 25000000, response window length in clk cycles.
- GAP_CYCLES, 12500000, LEDs-off gap before each round, in clk cycles.
- TIMER_W, 26, timer width; must hold max(WINDOW_CYCLES, GAP_CYCLES).
- LFSR_SEED, 8'hA5, LFSR reset value; nonzero.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- startGame  in  1  level from game controller; high while a game is running.
- btn  in  3  registered button levels (bit0 = button 1).
- ledTarget  out  3  one-hot target LED; 0 when no round is active.
- score  out  8  hits this game; saturates at 255.
- roundNum  out  8  rounds completed this game.
- hit  out  1  one-cycle pulse on a correct press.
- miss  out  1  one-cycle pulse on a wrong press or timeout.
- stopOut  out  1  level; high in DONE.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0; state IDLE; timer 0; btnPrev 0; lfsr=LFSR_SEED.
- Edges:
  - btnPrev registers btn every cycle.
  - edge = btn & ~btnPrev (combinational).
  - Only rising edges count; a held button never scores twice.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4; advances every cycle in every state.
  - Target index = lfsr mod 3, sampled on GAP->SHOW.
- States:
  - IDLE: on startGame=1, clear score and roundNum, load timer=GAP_CYCLES-1, go to GAP.
  - GAP: ledTarget=0; timer decrements. At timer==0, latch target, set ledTarget one-hot, load timer=WINDOW_CYCLES-1, go to SHOW.
  - SHOW: timer decrements. Priority, evaluated each cycle:
    1. Any edge on a non-target bit -> miss.
    2. Otherwise, edge on the target bit -> hit; score++ (saturating).
    3. Otherwise, timer==0 -> miss.
    - On any of these outcomes: ledTarget=0 and roundNum++. Then, if roundNum+1 == NUM_ROUNDS, go to DONE; else load timer=GAP_CYCLES-1 and go to GAP.
  - DONE: stopOut=1, ledTarget=0, score and roundNum held. When startGame falls, stopOut=0 and go to IDLE.
- Pulses and latency:
  - hit and miss are registered; high for exactly the cycle after the deciding edge or timeout; never both at once.
- Abort:
  - startGame=0 in GAP or SHOW -> IDLE next cycle; ledTarget=0; no pulse; score and roundNum held.
- Edge cases:
  - Restart: startGame re-rising in IDLE starts a new game and clears score.
  - Edge in GAP: ignored, no penalty.
  - Edge on the last window cycle (timer==0): the press takes precedence over timeout.
- Round count:
  - roundNum never exceeds NUM_ROUNDS.
- Illegal state: recover to IDLE with all outputs 0.

Decomposition:
- Package game_pkg:
  - state enum (IDLE, GAP, SHOW, DONE), 2-bit encoding.
  - NUM_BUTTONS=3.
  - LFSR tap constant.
- One sub-module, lfsr8:
  - Ports: clk, rst (async active-low), seed parameter, 8-bit q.
  - Free-running; keeps the sequencer FSM-only.

Test Plan (NUM_ROUNDS=3, WINDOW_CYCLES=8, GAP_CYCLES=4):
- Reset mid-SHOW (rst low asynchronously) -> all outputs 0 immediately, without a clk edge; state IDLE.
- startGame=1, correct button pulsed 2 cycles after ledTarget lights, each round -> hit pulse once per round, score=3, roundNum=3, stopOut=1 after round 3; stopOut=0 one cycle after startGame falls.
- No presses -> miss exactly 8 cycles after ledTarget lights, each round; score=0; stopOut=1 after 3 misses.
- Target LED 3'b010 lit, btn=3'b011 rising in the same cycle -> miss, not hit; score unchanged.
- Button held high across a GAP->SHOW transition -> no hit (no rising edge). Release then press -> hit.
- startGame dropped in SHOW after 1 hit -> IDLE next cycle; ledTarget=0; score=1 held; no pulse. New startGame -> score=0.
